// File: rtl/reg_file_mp.sv
// Multi-port register file: two combinational read ports, one byte-enabled write port,
// optional write bypass and hard-wired zero entry, plus a sequential clear sweep.
module reg_file_mp #(
    parameter int DW        = 32,
    parameter int AW        = 6,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG0 = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    output logic            busy,
    input  logic [AW-1:0]   rAddr1,
    output logic [DW-1:0]   rDout1,
    input  logic [AW-1:0]   rAddr2,
    output logic [DW-1:0]   rDout2,
    input  logic [AW-1:0]   wAddr,
    input  logic [DW-1:0]   wDin,
    input  logic [DW/8-1:0] wBe,
    input  logic            wEna,
    output logic            wDrop,
    output logic            o_dbg_state
);
    localparam int DEPTH = 2 ** AW;
    localparam int NB    = DW / 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_ptr;
    logic [AW-1:0]   w_ptr_nxt;
    logic            w_sweep_we;
    logic            w_wr_ok;
    logic            w_zero_addr;
    logic            w_drop_nxt;
    logic            r_drop;
    logic [DW-1:0]   r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sweep_we  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clr) begin
                    w_state_nxt = S_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            S_CLEAR: begin
                w_sweep_we = 1'b1;
                if (r_ptr == {AW{1'b1}}) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    assign busy        = (r_state == S_CLEAR);
    assign o_dbg_state = r_state;
    assign wDrop       = r_drop;

    // Writes to a hard-wired zero entry vanish silently, never reported as drops.
    assign w_zero_addr = (ZERO_REG0 != 0) && (wAddr == '0);
    assign w_wr_ok     = !busy && wEna && !w_zero_addr;
    assign w_drop_nxt  = busy && wEna && (wBe != '0) && !w_zero_addr;

    // No reset on the array so it can map onto distributed RAM; the sweep clears it.
    always_ff @(posedge clk) begin
        if (w_sweep_we && !rst) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr_ok) begin
            for (int k = 0; k < NB; k++) begin
                if (wBe[k]) r_mem[wAddr][8*k +: 8] <= wDin[8*k +: 8];
            end
        end
    end

    function automatic logic [DW-1:0] read_port(
        input logic [AW-1:0]   a,
        input logic [DW-1:0]   m,
        input logic            bsy,
        input logic            we,
        input logic [AW-1:0]   wa,
        input logic [DW-1:0]   wd,
        input logic [DW/8-1:0] be
    );
        logic [DW-1:0] v;
        v = m;
        if (bsy) begin
            v = '0;
        end else if ((ZERO_REG0 != 0) && (a == '0)) begin
            v = '0;
        end else if ((BYPASS != 0) && we && (a == wa)) begin
            for (int k = 0; k < NB; k++) begin
                if (be[k]) v[8*k +: 8] = wd[8*k +: 8];
            end
        end
        return v;
    endfunction

    always_comb begin
        rDout1 = read_port(rAddr1, r_mem[rAddr1], busy, wEna, wAddr, wDin, wBe);
        rDout2 = read_port(rAddr2, r_mem[rAddr2], busy, wEna, wAddr, wDin, wBe);
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: three configurations share one stimulus stream and are
// checked against a sweep-count/array model of the register file.
module tb_reg_file_mp;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [5:0]  r_addr1 = '0, r_addr2 = '0, w_addr = '0;
    logic [31:0] w_din = '0;
    logic [3:0]  w_be = '0;
    logic        w_ena = 1'b0;

    logic        busy_a, busy_n, busy_z;
    logic [31:0] d1_a, d2_a, d1_n, d2_n, d1_z, d2_z;
    logic        drop_a, drop_n, drop_z;
    logic        dbg_a, dbg_n, dbg_z;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem_m [DEPTH];
    int          clear_cnt = DEPTH;
    logic        exp_drop = 1'b0;

    always #5 clk = ~clk;

    reg_file_mp #(.DW(32), .AW(6), .BYPASS(1), .ZERO_REG0(0)) dut (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_a),
        .rAddr1(r_addr1), .rDout1(d1_a), .rAddr2(r_addr2), .rDout2(d2_a),
        .wAddr(w_addr), .wDin(w_din), .wBe(w_be), .wEna(w_ena),
        .wDrop(drop_a), .o_dbg_state(dbg_a));

    reg_file_mp #(.DW(32), .AW(6), .BYPASS(0), .ZERO_REG0(0)) dut_nb (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_n),
        .rAddr1(r_addr1), .rDout1(d1_n), .rAddr2(r_addr2), .rDout2(d2_n),
        .wAddr(w_addr), .wDin(w_din), .wBe(w_be), .wEna(w_ena),
        .wDrop(drop_n), .o_dbg_state(dbg_n));

    reg_file_mp #(.DW(32), .AW(6), .BYPASS(1), .ZERO_REG0(1)) dut_z (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_z),
        .rAddr1(r_addr1), .rDout1(d1_z), .rAddr2(r_addr2), .rDout2(d2_z),
        .wAddr(w_addr), .wDin(w_din), .wBe(w_be), .wEna(w_ena),
        .wDrop(drop_z), .o_dbg_state(dbg_z));

    // Expected read value seen by a port, given the configuration's options.
    function automatic logic [31:0] m_read(input logic [5:0] a, input bit byp, input bit zr);
        logic [31:0] v;
        if (clear_cnt > 0) return 32'h0;
        if (zr && a == 6'd0) return 32'h0;
        v = mem_m[a];
        if (byp && w_ena && a == w_addr)
            for (int k = 0; k < 4; k++) if (w_be[k]) v[8*k +: 8] = w_din[8*k +: 8];
        return v;
    endfunction

    // Advance the model by one rising edge, then wait for it in the DUT.
    task automatic tick();
        bit was_busy;
        was_busy = (clear_cnt > 0);
        if (rst) begin
            exp_drop  = 1'b0;
            clear_cnt = DEPTH;
        end else begin
            exp_drop = was_busy && w_ena && (w_be != 4'h0);
            if (was_busy) begin
                mem_m[DEPTH - clear_cnt] = 32'h0;
                clear_cnt--;
            end else begin
                if (w_ena)
                    for (int k = 0; k < 4; k++) if (w_be[k]) mem_m[w_addr][8*k +: 8] = w_din[8*k +: 8];
                if (clr) clear_cnt = DEPTH;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        w_ena = 1'b0; w_be = 4'h0; clr = 1'b0;
    endtask

    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        w_ena = 1'b1; w_addr = a; w_din = d; w_be = be;
        tick();
        idle_inputs();
    endtask

    task automatic check_ports(input string tag);
        #1;
        n_checks++;
        if (d1_a !== m_read(r_addr1, 1, 0) || d2_a !== m_read(r_addr2, 1, 0)) begin
            n_fail++;
            $display("FAIL %s byp p1=%h p2=%h want %h %h", tag, d1_a, d2_a, m_read(r_addr1, 1, 0), m_read(r_addr2, 1, 0));
        end
        n_checks++;
        if (d1_n !== m_read(r_addr1, 0, 0) || d2_n !== m_read(r_addr2, 0, 0)) begin
            n_fail++;
            $display("FAIL %s nobyp p1=%h p2=%h want %h %h", tag, d1_n, d2_n, m_read(r_addr1, 0, 0), m_read(r_addr2, 0, 0));
        end
        n_checks++;
        if (d1_z !== m_read(r_addr1, 1, 1) || d2_z !== m_read(r_addr2, 1, 1)) begin
            n_fail++;
            $display("FAIL %s zero p1=%h p2=%h want %h %h", tag, d1_z, d2_z, m_read(r_addr1, 1, 1), m_read(r_addr2, 1, 1));
        end
    endtask

    task automatic check_all_entries(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            r_addr1 = 6'(i); r_addr2 = 6'(DEPTH - 1 - i);
            check_ports(tag);
        end
    endtask

    // Runs the sweep to completion with idle inputs, checking busy every cycle.
    task automatic run_sweep(input string tag, output int cycles);
        cycles = 0;
        while (clear_cnt > 0 && cycles < 200) begin
            n_checks++;
            if (busy_a !== 1'b1 || busy_n !== 1'b1 || busy_z !== 1'b1) begin
                n_fail++;
                $display("FAIL %s busy cycle %0d got %b%b%b want 111", tag, cycles, busy_a, busy_n, busy_z);
            end
            tick();
            cycles++;
        end
        n_checks++;
        if (busy_a !== 1'b0 || busy_n !== 1'b0 || busy_z !== 1'b0 || cycles != DEPTH) begin
            n_fail++;
            $display("FAIL %s end busy=%b%b%b cycles=%0d want 000 %0d", tag, busy_a, busy_n, busy_z, cycles, DEPTH);
        end
    endtask

    task automatic test_reset();
        int cyc;
        rst = 1'b1;
        idle_inputs();
        repeat (3) tick();
        n_checks++;
        if (busy_a !== 1'b1 || drop_a !== 1'b0 || d1_a !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state busy=%b drop=%b dout=%h want 1 0 0", busy_a, drop_a, d1_a);
        end
        rst = 1'b0;
        run_sweep("reset_sweep", cyc);
        check_all_entries("reset_zero");
    endtask

    task automatic test_bytes();
        do_write(6'd5, 32'hDEADBEEF, 4'hF);
        do_write(6'd5, 32'h11223344, 4'b0101);
        r_addr1 = 6'd5; r_addr2 = 6'd5;
        check_ports("bytes_model");
        n_checks++;
        if (d1_a !== 32'hDE22BE44) begin
            n_fail++;
            $display("FAIL bytes_const got %h want DE22BE44", d1_a);
        end
        do_write(6'd6, 32'hCAFEF00D, 4'h0);
        r_addr1 = 6'd6;
        check_ports("be_zero_noop");
        n_checks++;
        if (drop_a !== 1'b0) begin
            n_fail++;
            $display("FAIL be_zero_drop got %b want 0", drop_a);
        end
    endtask

    task automatic test_bypass();
        do_write(6'd9, 32'hAAAAAAAA, 4'hF);
        w_ena = 1'b1; w_addr = 6'd9; w_din = 32'h12345678; w_be = 4'b0011;
        r_addr1 = 6'd9; r_addr2 = 6'd9;
        check_ports("bypass_model");
        n_checks++;
        if (d1_a !== 32'hAAAA5678 || d2_a !== 32'hAAAA5678 || d1_n !== 32'hAAAAAAAA || d2_n !== 32'hAAAAAAAA) begin
            n_fail++;
            $display("FAIL bypass_const byp=%h/%h nobyp=%h/%h want AAAA5678 AAAAAAAA", d1_a, d2_a, d1_n, d2_n);
        end
        tick();
        idle_inputs();
        check_ports("bypass_after");
        n_checks++;
        if (d1_n !== 32'hAAAA5678) begin
            n_fail++;
            $display("FAIL nobyp_after got %h want AAAA5678", d1_n);
        end
    endtask

    task automatic test_zero();
        w_ena = 1'b1; w_addr = 6'd0; w_din = 32'hFFFFFFFF; w_be = 4'hF;
        r_addr1 = 6'd0; r_addr2 = 6'd1;
        check_ports("zero_bypass");
        n_checks++;
        if (d1_z !== 32'h0 || d1_a !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL zero_bypass_const zero=%h byp=%h want 0 FFFFFFFF", d1_z, d1_a);
        end
        tick();
        idle_inputs();
        check_ports("zero_after");
        n_checks++;
        if (drop_z !== 1'b0 || d1_z !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_after drop=%b dout=%h want 0 0", drop_z, d1_z);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            w_ena   = 1'($urandom_range(0, 1));
            w_addr  = 6'($urandom_range(0, DEPTH - 1));
            w_din   = $urandom;
            w_be    = 4'($urandom_range(0, 15));
            r_addr1 = ($urandom_range(0, 3) == 0) ? w_addr : 6'($urandom_range(0, DEPTH - 1));
            r_addr2 = ($urandom_range(0, 3) == 0) ? w_addr : 6'($urandom_range(0, DEPTH - 1));
            check_ports("random");
            tick();
            n_checks++;
            if (drop_a !== exp_drop || drop_n !== exp_drop) begin
                n_fail++;
                $display("FAIL random_drop got %b%b want %b", drop_a, drop_n, exp_drop);
            end
        end
        idle_inputs();
        check_all_entries("random_final");
    endtask

    task automatic test_clear();
        int cyc;
        for (int i = 0; i < DEPTH; i++) do_write(6'(i), 32'(i), 4'hF);
        check_all_entries("fill");
        clr = 1'b1; w_ena = 1'b1; w_addr = 6'd7; w_din = 32'h5555AAAA; w_be = 4'hF;
        tick();
        idle_inputs();
        cyc = 0;
        while (clear_cnt > 0 && cyc < 200) begin
            n_checks++;
            if (busy_a !== 1'b1) begin
                n_fail++;
                $display("FAIL clr_busy cycle %0d got %b want 1", cyc, busy_a);
            end
            idle_inputs();
            if (cyc == 10) do_write(6'd3, 32'h0BADF00D, 4'hF);
            else begin
                if (cyc == 20) clr = 1'b1;
                tick();
            end
            n_checks++;
            if (drop_a !== exp_drop || drop_z !== exp_drop) begin
                n_fail++;
                $display("FAIL clr_drop cycle %0d got %b%b want %b", cyc, drop_a, drop_z, exp_drop);
            end
            cyc++;
        end
        n_checks++;
        if (busy_a !== 1'b0 || cyc != DEPTH) begin
            n_fail++;
            $display("FAIL clr_length busy=%b cycles=%0d want 0 %0d", busy_a, cyc, DEPTH);
        end
        idle_inputs();
        check_all_entries("clr_zero");
    endtask

    task automatic test_rst_mid();
        int cyc;
        for (int i = 0; i < DEPTH; i++) do_write(6'(i), 32'hF0000000 | 32'(i), 4'hF);
        clr = 1'b1;
        tick();
        idle_inputs();
        repeat (30) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        run_sweep("rst_mid", cyc);
        check_all_entries("rst_mid_zero");
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
        test_reset();
        test_bytes();
        test_bypass();
        test_zero();
        test_random();
        test_clear();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file, successor to the fixed 64x32 register file. Features:
- two asynchronous read ports and one byte-enabled write port on the rising clock edge;
- optional write-to-read bypass and optional hard-wired zero register;
- a sequential clear engine, so the storage array has no parallel reset and can map to distributed RAM.

Sits between decode (read addresses) and writeback (write port) in the CPU datapath.

Parameters:
DW, 32, data width in bits; must be a multiple of 8
AW, 6, address width; DEPTH = 2**AW entries
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
ZERO_REG0, 0, 1 = entry 0 reads as 0 and ignores writes

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset; starts the clear sweep
clr  in  1  synchronous clear request; starts the clear sweep when idle
busy  out  1  high while the clear sweep runs
rAddr1  in  AW  read address, port 1
rDout1  out  DW  read data, port 1 (combinational)
rAddr2  in  AW  read address, port 2
rDout2  out  DW  read data, port 2 (combinational)
wAddr  in  AW  write address
wDin  in  DW  write data
wBe  in  DW/8  byte enables; bit k covers wDin[8k+7:8k]
wEna  in  1  write enable
wDrop  out  1  registered one-cycle pulse: write was discarded

Behaviour:
- FSM states:
  - IDLE: normal operation.
  - CLEAR: writes 0 to mem[ptr] each cycle. ptr is an AW-bit counter.
- Reset values: state=CLEAR, ptr=0, busy=1, wDrop=0. rDout1/rDout2 read 0 while busy.
- While rst is high, the FSM holds CLEAR with ptr=0 and no array write occurs.
- First edge with rst low: the sweep writes mem[0].
  - The k-th such edge writes mem[k-1].
  - The edge that writes mem[DEPTH-1] also sets state=IDLE and busy=0.
  - Sweep length is exactly DEPTH cycles after rst falls.
- rst asserted mid-sweep: ptr returns to 0 and the sweep restarts from entry 0.
- clr sampled high in IDLE: next edge enters CLEAR with ptr=0 and busy=1. The sweep then takes DEPTH cycles, the same as after reset.
- clr in CLEAR: ignored, no restart.
- clr and wEna high in the same IDLE cycle: the write is performed and the sweep starts next cycle. That write is overwritten by the sweep.
- Writes in IDLE:
  - On a rising edge with wEna=1, each byte k with wBe[k]=1 is updated from wDin. Other bytes keep their value.
  - wEna=1 with wBe=0 is a no-op and not a drop.
- Writes while busy: discarded; wDrop=1 on the following cycle. Otherwise wDrop=0.
- wAddr=0 with ZERO_REG0=1: write ignored, no wDrop.
- Reads: rDoutN = mem[rAddrN], combinational, zero latency.
  - Write data becomes visible from the array the cycle after the write edge.
- Bypass (BYPASS=1, state IDLE, wEna=1, rAddrN==wAddr): rDoutN is the byte-wise merge of wDin under wBe over mem[wAddr], in the same cycle.
  - Both ports bypass independently when both match.
- BYPASS=0: rDoutN shows the old value until after the edge.
- ZERO_REG0=1 with rAddrN=0: rDoutN=0 always, with or without bypass.
- Priority on rDoutN: busy -> 0; else zero-reg -> 0; else bypass; else array.
- Address wrap: ptr wraps from DEPTH-1 to 0 only on sweep completion. No out-of-range addresses exist.
- No X propagation: every entry is written by the reset sweep before it can be read.

Test Plan:
1. Reset and sweep, DW=32, AW=6:
   - Assert rst for 3 cycles, then release -> busy=1 for exactly 64 cycles after release, then busy=0.
   - All 64 entries read 0x00000000 on both ports.
2. Write/readback and bytes:
   - Write 0xDEADBEEF to addr 5, wBe=4'hF; next cycle write 0x11223344 to addr 5, wBe=4'b0101.
   - rDout1 at addr 5 reads 0xDE22BE44 after the second edge.
3. Bypass, BYPASS=1:
   - Addr 9 holds 0xAAAAAAAA. Drive wEna=1, wAddr=9, wDin=0x12345678, wBe=4'b0011, rAddr1=rAddr2=9.
   - Both ports show 0xAAAA5678 in the same cycle.
   - Repeat with BYPASS=0 -> 0xAAAAAAAA until the edge.
4. Zero register, ZERO_REG0=1:
   - Write 0xFFFFFFFF to addr 0 -> rDout1 at addr 0 reads 0. wDrop stays 0.
   - Bypass does not override the zero.
5. Clear mid-operation:
   - Fill addrs 0..63 with their index. Pulse clr -> busy high 64 cycles, all entries read 0.
   - A write to addr 3 at sweep cycle 10 gives wDrop=1 for one cycle; addr 3 reads 0 afterward.
   - A clr pulse during the sweep does not extend it.
6. Reset mid-sweep:
   - Assert rst at sweep cycle 30 -> after release, busy lasts a full 64 cycles, and entries 30..63 read 0.
